// File: rtl/udp_rx_parser_pkg.sv
// udp_rx_parser_pkg: FSM state type and fixed Ethernet/IPv4/UDP header layout constants.
package udp_rx_parser_pkg;
    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL  = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [5:0]  OFF_ETH_TYPE  = 6'd12;
    localparam logic [5:0]  OFF_VER_IHL   = 6'd14;
    localparam logic [5:0]  OFF_PROTO     = 6'd23;
    localparam logic [5:0]  OFF_SRC_PORT  = 6'd34;
    localparam logic [5:0]  OFF_DST_PORT  = 6'd36;
    localparam logic [5:0]  OFF_UDP_LEN   = 6'd38;
    localparam logic [5:0]  HDR_LEN       = 6'd42;
endpackage

// File: rtl/udp_rx_parser.sv
// udp_rx_parser: filters IPv4/UDP frames for one destination port and streams their payload
// through a one-entry output register, counting discarded and truncated frames.
module udp_rx_parser import udp_rx_parser_pkg::*; #(
    parameter logic [15:0] UDP_PORT = 16'd5000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [7:0]       in_tdata,
    input  logic             in_tlast,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [7:0]       out_tdata,
    output logic             out_tlast,
    output logic [15:0]      src_port,
    output logic [15:0]      pay_len,
    output logic             frame_ok,
    output logic [CNT_W-1:0] drop_count
);
    state_t      state, state_n;
    logic [5:0]  cnt;
    logic [15:0] rem, src_tmp, ulen, field;
    logic [7:0]  prev;
    logic        in_fire, out_fire, last_ok, hdr_bad, drop_inc;

    assign in_tready = (state == PAYLOAD) ? (!out_tvalid || out_tready) : 1'b1;
    assign in_fire   = in_tvalid && in_tready;
    assign out_fire  = out_tvalid && out_tready;
    assign field     = {prev, in_tdata};
    assign frame_ok  = out_fire && out_tlast && last_ok;

    // Two-byte fields are judged only on their second byte, using the held first byte.
    always_comb begin
        hdr_bad = (cnt == OFF_ETH_TYPE + 6'd1 && field != ETH_TYPE_IPV4) ||
                  (cnt == OFF_VER_IHL && in_tdata != IPV4_VER_IHL) ||
                  (cnt == OFF_PROTO && in_tdata != IP_PROTO_UDP) ||
                  (cnt == OFF_DST_PORT + 6'd1 && field != UDP_PORT) ||
                  (cnt == OFF_UDP_LEN + 6'd1 && field <= 16'd8);
        state_n  = state;
        drop_inc = 1'b0;
        if (in_fire) begin
            case (state)
                HDR: begin
                    if (in_tlast) begin
                        state_n  = HDR;
                        drop_inc = 1'b1;
                    end else if (hdr_bad) begin
                        state_n  = DROP;
                        drop_inc = 1'b1;
                    end else if (cnt == HDR_LEN - 6'd1) begin
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (rem == 16'd1) begin
                        state_n = in_tlast ? HDR : DROP;
                    end else if (in_tlast) begin
                        state_n  = HDR;
                        drop_inc = 1'b1;
                    end
                end
                DROP:    state_n = in_tlast ? HDR : DROP;
                default: state_n = HDR;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HDR;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            rem        <= '0;
            prev       <= '0;
            src_tmp    <= '0;
            ulen       <= '0;
            src_port   <= '0;
            pay_len    <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tlast  <= 1'b0;
            last_ok    <= 1'b0;
            drop_count <= '0;
        end else begin
            if (in_fire && state == HDR) begin
                cnt  <= (state_n == HDR && !in_tlast) ? cnt + 6'd1 : 6'd0;
                prev <= in_tdata;
                if (cnt == OFF_SRC_PORT + 6'd1) src_tmp <= field;
                if (cnt == OFF_UDP_LEN + 6'd1)  ulen    <= field;
                if (state_n == PAYLOAD) begin
                    src_port <= src_tmp;
                    pay_len  <= ulen - 16'd8;
                    rem      <= ulen - 16'd8;
                end
            end
            if (in_fire && state == PAYLOAD) begin
                rem        <= rem - 16'd1;
                out_tvalid <= 1'b1;
                out_tdata  <= in_tdata;
                out_tlast  <= (rem == 16'd1) || in_tlast;
                last_ok    <= rem == 16'd1;
            end else if (out_fire) begin
                out_tvalid <= 1'b0;
                out_tlast  <= 1'b0;
            end
            if (drop_inc && !(&drop_count)) drop_count <= drop_count + CNT_W'(1);
        end
    end
endmodule
